// File: rtl/ts_pkg.sv
// ts_pkg: shared constants and state encodings for the TS output arbiter
package ts_pkg;
  localparam logic [7:0] TS_SYNC = 8'h47;
  localparam int NUM_CH = 4;
  typedef enum logic [1:0] {W_HUNT, W_FILL, W_DROP} wr_state_e;
  typedef enum logic {A_IDLE, A_SEND} arb_state_e;
endpackage

// File: rtl/ts_pkt_buffer.sv
// ts_pkt_buffer: per-channel sync-hunting packet writer with a ping-pong pair of packet halves
module ts_pkt_buffer
  import ts_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN = 188,
  localparam int IW = $clog2(PKT_LEN),
  localparam int AW = $clog2(2 * PKT_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  din_valid_i,
  input  logic [IW-1:0]         rd_idx_i,
  input  logic                  free_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  avail_o,
  output logic                  drop_o
);
  wr_state_e st_q;
  logic [IW-1:0] widx_q;
  logic wr_half_q, rd_half_q;
  logic [1:0] full_q;
  logic [DATA_WIDTH-1:0] mem [2*PKT_LEN];
  logic is_sync, start, we, last, done;
  logic [AW-1:0] waddr, raddr;
  assign is_sync = din_valid_i && din_i == TS_SYNC;
  assign start = st_q == W_HUNT && is_sync && !full_q[wr_half_q];
  assign we = start || (st_q == W_FILL && din_valid_i);
  assign last = widx_q == IW'(PKT_LEN - 1);
  assign done = st_q == W_FILL && din_valid_i && last;
  assign waddr = AW'(wr_half_q ? PKT_LEN : 0) + AW'(widx_q);
  assign raddr = AW'(rd_half_q ? PKT_LEN : 0) + AW'(rd_idx_i);
  assign rd_data_o = mem[raddr];
  assign avail_o = full_q[rd_half_q];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= din_i;
  // halves fill and drain in strict alternation, so a full write half means both are full
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= W_HUNT;
      widx_q <= '0;
      wr_half_q <= 1'b0;
      rd_half_q <= 1'b0;
      full_q <= '0;
      drop_o <= 1'b0;
    end else begin
      drop_o <= st_q == W_HUNT && is_sync && full_q[wr_half_q];
      full_q <= (full_q & ~(free_i ? 2'b01 << rd_half_q : 2'b00)) | (done ? 2'b01 << wr_half_q : 2'b00);
      if (free_i) rd_half_q <= ~rd_half_q;
      if (st_q == W_HUNT) begin
        if (is_sync) begin
          st_q <= full_q[wr_half_q] ? W_DROP : W_FILL;
          widx_q <= IW'(1);
        end
      end else if (din_valid_i) begin
        widx_q <= last ? '0 : widx_q + IW'(1);
        if (last) st_q <= W_HUNT;
        if (done) wr_half_q <= ~wr_half_q;
      end
    end
  end
endmodule

// File: rtl/top_fifo_out_arb.sv
// top_fifo_out_arb: round-robin arbiter muxing whole TS packets from four channel buffers
module top_fifo_out_arb
  import ts_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN = 188
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  input  logic [DATA_WIDTH-1:0] rdata3,
  input  logic [DATA_WIDTH-1:0] rdata4,
  input  logic                  valid_out1,
  input  logic                  valid_out2,
  input  logic                  valid_out3,
  input  logic                  valid_out4,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [1:0]            out_ch,
  output logic [3:0]            drop_pulse
);
  localparam int IW = $clog2(PKT_LEN);
  logic [DATA_WIDTH-1:0] din [NUM_CH];
  logic [DATA_WIDTH-1:0] rd [NUM_CH];
  logic [NUM_CH-1:0] dval, avail, free;
  arb_state_e st_q;
  logic [1:0] ptr_q, gnt;
  logic found, fire;
  logic [IW-1:0] idx_q, rd_idx;
  assign din = '{rdata1, rdata2, rdata3, rdata4};
  assign dval = {valid_out4, valid_out3, valid_out2, valid_out1};
  assign fire = out_valid && out_ready;
  assign rd_idx = (st_q == A_SEND && !out_eop) ? idx_q + IW'(1) : '0;
  assign free = (fire && out_eop) ? NUM_CH'(1) << out_ch : '0;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ts_pkt_buffer #(.DATA_WIDTH(DATA_WIDTH), .PKT_LEN(PKT_LEN)) u_buf (
      .clk(rclk),
      .rst(rrst),
      .din_i(din[g]),
      .din_valid_i(dval[g]),
      .rd_idx_i(rd_idx),
      .free_i(free[g]),
      .rd_data_o(rd[g]),
      .avail_o(avail[g]),
      .drop_o(drop_pulse[g])
    );
  end
  // scan downward so the channel closest after the pointer wins
  always_comb begin
    found = 1'b0;
    gnt = ptr_q;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (avail[ptr_q + 2'(k)]) begin
        found = 1'b1;
        gnt = ptr_q + 2'(k);
      end
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      st_q <= A_IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
    end else if (st_q == A_IDLE) begin
      if (found) begin
        st_q <= A_SEND;
        ptr_q <= gnt + 2'd1;
        out_ch <= gnt;
        idx_q <= '0;
        out_valid <= 1'b1;
        out_sop <= 1'b1;
        out_eop <= 1'b0;
        out_data <= rd[gnt];
      end
    end else if (fire) begin
      if (out_eop) begin
        st_q <= A_IDLE;
        out_valid <= 1'b0;
        out_sop <= 1'b0;
        out_eop <= 1'b0;
      end else begin
        idx_q <= idx_q + IW'(1);
        out_data <= rd[out_ch];
        out_sop <= 1'b0;
        out_eop <= idx_q == IW'(PKT_LEN - 2);
      end
    end
  end
endmodule
